pc_fetch_unit: RTL and testbench
================================

# pc_fetch_unit

Program-counter and instruction-fetch stage of the single-cycle MIPS core, directly upstream of the control unit. It holds the PC and fetches each instruction word from instruction memory through a req/ready handshake. It presents the word to the decoder, then computes the next PC from the decoder's PCSrc/Jump outputs and the sign-extended immediate. An instruction-memory timeout drives the block into a sticky error state.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be word-aligned.
- TIMEOUT, 16, consecutive WAIT cycles without IMemReady before error; 0 disables the timeout.
- clk  input  1  single clock, rising edge.
- rst_n  input  1  synchronous, active-low reset.
- PCSrc  input  1  branch taken (Branch & zero) from control unit.
- Jump  input  1  jump from control unit.
- SignImm  input  32  sign-extended Instr[15:0] from datapath.
- Stall  input  1  holds the current instruction in EXEC.
- IMemReady  input  1  instruction memory has valid IMemRdata this cycle.
- IMemRdata  input  32  instruction word.
- IMemReq  output  1  fetch request.
- IMemAddr  output  32  fetch address; equals PC.
- Instr  output  32  registered instruction word; OpCode = Instr[31:26], Funct = Instr[5:0].
- InstrValid  output  1  Instr is executing this cycle; the datapath commits only when this is high.
- PC  output  32  current PC.
- PCPlus4  output  32  PC + 4.
- FetchErr  output  1  sticky timeout flag.

## Operation
- States: IDLE, WAIT, EXEC, ERROR. Moore outputs: IMemReq=1 only in WAIT; InstrValid=1 only in EXEC; FetchErr=1 only in ERROR.
- IDLE -> WAIT unconditionally. IDLE is entered only from reset.
- WAIT:
  - IMemReady=1: Instr <= IMemRdata, clear the timeout counter, go to EXEC.
  - Otherwise, if TIMEOUT != 0 and the counter equals TIMEOUT-1: go to ERROR.
  - Otherwise: counter += 1.
- EXEC:
  - Stall=1: hold PC, Instr and state.
  - Stall=0: PC <= NextPC, go to WAIT.
- NextPC priority:
  - Jump=1: {PCPlus4[31:28], Instr[25:0], 2'b00}. Jump wins if PCSrc is also high.
  - Else PCSrc=1: PCPlus4 + (SignImm << 2), modulo 2^32.
  - Else: PCPlus4.
- All PC arithmetic is 32-bit with silent wrap: PC=32'hFFFF_FFFC gives PCPlus4=32'h0000_0000.
- ERROR is absorbing. PC and Instr hold, and IMemReq=0. Only reset exits.
- IMemReady and IMemRdata are ignored outside WAIT.
- PCSrc, Jump, SignImm and Stall are ignored outside EXEC.
- Counter width is $clog2(TIMEOUT+1), minimum 1 bit.

## Timing
- Reset (rst_n=0 at an edge) sets:
  - state=IDLE, PC=RESET_PC, Instr=0, counter=0;
  - IMemReq=0, InstrValid=0, FetchErr=0.
- Reset has priority over all other inputs in every state, including mid-WAIT and mid-EXEC.
- First IMemReq is asserted the cycle after rst_n is sampled high.
- Ready is sampled high in WAIT cycle n -> InstrValid=1 and the new Instr appear in cycle n+1.
- Minimum instruction period is 2 cycles (WAIT, EXEC) with zero-wait memory.
- IMemAddr is stable for the whole WAIT residency. Memory may assert ready in the first WAIT cycle.
- PC updates at the edge ending an unstalled EXEC cycle. PCSrc and Jump are combinational from Instr in that same cycle.
- Timeout: ERROR is entered at the edge ending the TIMEOUT-th consecutive ready-low WAIT cycle. Ready high in that same cycle wins: EXEC, no error.

## Test plan
- Reset/sequential: RESET_PC=0, zero-wait memory, four non-branch words.
  - IMemAddr sequence 0,4,8,C.
  - InstrValid pulses every 2nd cycle.
  - All outputs at their reset values during rst_n=0.
- Branch/jump:
  - Instr at PC=0x10 with PCSrc=1, SignImm=-2 -> next IMemAddr=0x0C.
  - Jump=1, Instr[25:0]=26'h0000040, PC=0x0C -> next IMemAddr=0x100.
  - PCSrc=1 and Jump=1 together -> jump target.
- Wait states and stall:
  - Ready delayed 3 cycles -> IMemReq high 4 cycles, address constant.
  - Stall=1 for 2 EXEC cycles -> InstrValid high 3 cycles, PC unchanged until Stall drops.
- Timeout, TIMEOUT=4:
  - Ready never asserted -> FetchErr=1 after 4 WAIT cycles; IMemReq=0 thereafter.
  - Ready asserted in the 4th cycle -> no error.
  - Reset clears FetchErr.
- Wrap and reset mid-operation:
  - RESET_PC=32'hFFFF_FFFC -> second fetch at 0x0.
  - rst_n=0 during WAIT and during Stall=1 EXEC -> PC=RESET_PC, state IDLE next cycle.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction fetch stage of the single-cycle MIPS core.
// Fetches one word per instruction over a req/ready handshake, holds it for the
// decoder while executing, then advances the PC from the decoder's PCSrc/Jump.
// A run of ready-low WAIT cycles reaching TIMEOUT parks the unit in a sticky ERROR.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        PCSrc,
    input  logic        Jump,
    input  logic [31:0] SignImm,
    input  logic        Stall,
    input  logic        IMemReady,
    input  logic [31:0] IMemRdata,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    output logic [31:0] Instr,
    output logic        InstrValid,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic        FetchErr
);

    // $clog2(1) is 0, so a disabled timeout still gets a 1-bit counter.
    localparam int unsigned CntW        = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam int unsigned TimeoutLast = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
    localparam logic [CntW-1:0] CntLast = TimeoutLast[CntW-1:0];

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StExec,
        StError
    } state_e;

    state_e            state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic [31:0]       instr_q, instr_d;
    logic [CntW-1:0]   cnt_q, cnt_d;

    logic [31:0]       pc_plus4;
    logic [31:0]       branch_target;
    logic [31:0]       jump_target;
    logic [31:0]       next_pc;

    // Next-PC selection; all additions wrap silently at 32 bits.
    always_comb begin
        pc_plus4      = pc_q + 32'd4;
        branch_target = pc_plus4 + {SignImm[29:0], 2'b00};
        jump_target   = {pc_plus4[31:28], instr_q[25:0], 2'b00};
        next_pc       = pc_plus4;
        if (Jump) begin
            next_pc = jump_target;
        end else if (PCSrc) begin
            next_pc = branch_target;
        end
    end

    // Next-state logic; inputs are only looked at in the state that owns them.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                state_d = StWait;
            end
            StWait: begin
                if (IMemReady) begin
                    instr_d = IMemRdata;
                    cnt_d   = '0;
                    state_d = StExec;
                end else if ((TIMEOUT != 0) && (cnt_q == CntLast)) begin
                    state_d = StError;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StExec: begin
                if (!Stall) begin
                    pc_d    = next_pc;
                    state_d = StWait;
                end
            end
            StError: begin
                state_d = StError;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        IMemReq    = (state_q == StWait);
        InstrValid = (state_q == StExec);
        FetchErr   = (state_q == StError);
        IMemAddr   = pc_q;
        PC         = pc_q;
        PCPlus4    = pc_plus4;
        Instr      = instr_q;
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: stimulus tasks queue the expected fetch
// addresses and executing {PC, Instr} pairs; a negedge monitor pops and compares
// whenever the DUT raises IMemReq or InstrValid.
module tb_pc_fetch_unit;

    localparam logic [31:0] RstPc = 32'hFFFF_FFFC;
    localparam int unsigned Tmo   = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        PCSrc;
    logic        Jump;
    logic [31:0] SignImm;
    logic        Stall;
    logic        IMemReady;
    logic [31:0] IMemRdata;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic [31:0] Instr;
    logic        InstrValid;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        FetchErr;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exec_t;

    logic [31:0] addr_q[$];
    exec_t       exec_q[$];
    int          checks = 0;
    int          errors = 0;

    pc_fetch_unit #(
        .RESET_PC (RstPc),
        .TIMEOUT  (Tmo)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .PCSrc      (PCSrc),
        .Jump       (Jump),
        .SignImm    (SignImm),
        .Stall      (Stall),
        .IMemReady  (IMemReady),
        .IMemRdata  (IMemRdata),
        .IMemReq    (IMemReq),
        .IMemAddr   (IMemAddr),
        .Instr      (Instr),
        .InstrValid (InstrValid),
        .PC         (PC),
        .PCPlus4    (PCPlus4),
        .FetchErr   (FetchErr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every request / executing cycle consumes one queued expectation.
    always @(negedge clk) begin
        exec_t e;
        if (IMemReq === 1'b1) begin
            if (addr_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_req: got addr %h expected no request", IMemAddr);
            end else begin
                chk("fetch_addr", IMemAddr, addr_q.pop_front());
            end
            chk("req_valid_excl", {31'b0, InstrValid}, 32'd0);
        end
        if (InstrValid === 1'b1) begin
            if (exec_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got pc %h expected no valid", PC);
            end else begin
                e = exec_q.pop_front();
                chk("exec_pc", PC, e.pc);
                chk("exec_instr", Instr, e.instr);
                chk("exec_pcplus4", PCPlus4, e.pc + 32'd4);
                chk("exec_fetcherr", {31'b0, FetchErr}, 32'd0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Inputs the DUT must ignore outside their owning state are driven noisy.
    task automatic noise();
        Stall     = 1'b1;
        PCSrc     = 1'b1;
        Jump      = 1'b1;
        SignImm   = 32'h1234_5678;
        IMemReady = 1'b0;
        IMemRdata = 32'hDEAD_BEEF;
    endtask

    task automatic wait_phase(input logic [31:0] addr, input int ncyc,
                              input logic [31:0] word, input bit ready_last);
        for (int i = 0; i < ncyc; i++) begin
            addr_q.push_back(addr);
            IMemReady = ready_last && (i == ncyc - 1);
            IMemRdata = IMemReady ? word : 32'hDEAD_BEEF;
            step();
        end
        noise();
    endtask

    task automatic exec_phase(input logic [31:0] addr, input logic [31:0] word, input int nstall,
                              input bit pcsrc, input bit jump, input logic [31:0] imm);
        for (int i = 0; i <= nstall; i++) begin
            exec_q.push_back('{pc: addr, instr: word});
            Stall     = (i < nstall);
            PCSrc     = pcsrc;
            Jump      = jump;
            SignImm   = imm;
            IMemReady = 1'b1;
            IMemRdata = 32'hBAD0_BAD0;
            step();
        end
        noise();
    endtask

    task automatic instr(input logic [31:0] addr, input int delay, input logic [31:0] word,
                         input int nstall, input bit pcsrc, input bit jump,
                         input logic [31:0] imm);
        wait_phase(addr, delay + 1, word, 1'b1);
        exec_phase(addr, word, nstall, pcsrc, jump, imm);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_req"}, {31'b0, IMemReq}, 32'd0);
        chk({tag, "_valid"}, {31'b0, InstrValid}, 32'd0);
        chk({tag, "_err"}, {31'b0, FetchErr}, 32'd0);
        chk({tag, "_pc"}, PC, RstPc);
        chk({tag, "_addr"}, IMemAddr, RstPc);
        chk({tag, "_pcplus4"}, PCPlus4, 32'h0000_0000);
        chk({tag, "_instr"}, Instr, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        noise();
        step();
        step();
        check_reset("reset");
        rst_n = 1'b1;
        step();  // IDLE -> WAIT

        // Sequential fetch with the PC wrapping from FFFF_FFFC to 0.
        instr(32'hFFFF_FFFC, 0, 32'h2001_0001, 0, 1'b0, 1'b0, 32'd0);
        instr(32'h0000_0000, 0, 32'h2002_0002, 0, 1'b0, 1'b0, 32'd0);
        instr(32'h0000_0004, 0, 32'h0022_1820, 0, 1'b0, 1'b0, 32'd0);
        instr(32'h0000_0008, 0, 32'hAC03_0000, 0, 1'b0, 1'b0, 32'd0);
        // Three wait states, then branch back by two words, then jump.
        instr(32'h0000_000C, 3, 32'h8C04_0004, 0, 1'b0, 1'b0, 32'd0);
        instr(32'h0000_0010, 0, 32'h1000_FFFE, 0, 1'b1, 1'b0, 32'hFFFF_FFFE);
        instr(32'h0000_000C, 0, 32'h0800_0040, 0, 1'b0, 1'b1, 32'd0);
        // Two stalled EXEC cycles, then jump wins over a simultaneous branch.
        instr(32'h0000_0100, 0, 32'h2005_0005, 2, 1'b0, 1'b0, 32'd0);
        instr(32'h0000_0104, 0, 32'h0800_0080, 0, 1'b1, 1'b1, 32'h0000_0005);
        instr(32'h0000_0200, 0, 32'h1000_0010, 0, 1'b1, 1'b0, 32'h0000_0010);
        // Ready in the last allowed WAIT cycle: no error.
        instr(32'h0000_0244, 3, 32'h2006_0006, 0, 1'b0, 1'b0, 32'd0);

        // Ready never arrives: ERROR after four WAIT cycles, then absorbing.
        wait_phase(32'h0000_0248, 4, 32'd0, 1'b0);
        chk("tmo_err", {31'b0, FetchErr}, 32'd1);
        chk("tmo_req", {31'b0, IMemReq}, 32'd0);
        chk("tmo_valid", {31'b0, InstrValid}, 32'd0);
        chk("tmo_pc", PC, 32'h0000_0248);
        chk("tmo_instr", Instr, 32'h2006_0006);
        IMemReady = 1'b1;
        IMemRdata = 32'h1111_2222;
        Stall     = 1'b0;
        step();
        step();
        chk("err_hold_err", {31'b0, FetchErr}, 32'd1);
        chk("err_hold_req", {31'b0, IMemReq}, 32'd0);
        chk("err_hold_pc", PC, 32'h0000_0248);
        chk("err_hold_instr", Instr, 32'h2006_0006);
        noise();
        rst_n = 1'b0;
        step();
        check_reset("err_reset");
        rst_n = 1'b1;
        step();

        // Reset in the third WAIT cycle beats a ready in that same cycle.
        wait_phase(RstPc, 2, 32'd0, 1'b0);
        addr_q.push_back(RstPc);
        IMemReady = 1'b1;
        IMemRdata = 32'h3333_4444;
        rst_n     = 1'b0;
        step();
        check_reset("wait_reset");
        noise();
        rst_n = 1'b1;
        step();

        // Counter must have been cleared: four WAIT cycles still succeed.
        wait_phase(RstPc, 4, 32'h2007_0007, 1'b1);
        exec_q.push_back('{pc: RstPc, instr: 32'h2007_0007});
        Stall   = 1'b1;
        PCSrc   = 1'b0;
        Jump    = 1'b0;
        SignImm = 32'd0;
        rst_n   = 1'b0;
        step();
        check_reset("exec_reset");
        noise();
        rst_n = 1'b1;
        step();

        // Recovery after reset, ending with a reset while the next fetch waits.
        instr(RstPc, 0, 32'h2008_0008, 0, 1'b0, 1'b0, 32'd0);
        chk("recover_pc", PC, 32'h0000_0000);
        addr_q.push_back(32'h0000_0000);
        rst_n = 1'b0;
        step();
        check_reset("final_reset");
        step();

        chk("addr_q_empty", addr_q.size(), 32'd0);
        chk("exec_q_empty", exec_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of stimulus expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
